sound_sequencer: RTL

- Schedules every sound request in the air-hockey game and drives the single square-wave tone generator that feeds SPEAKER.
- Edge-detects collision/event flags, latches them as pending requests and arbitrates them by fixed priority at frame boundaries.
- Steps multi-note jingles and outputs half-period, enable and restart controls to the tone generator.

---
 rtl/sound_sequencer.sv | 279 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/sound_sequencer.sv
`timescale 1ns/1ps
// sound_sequencer
// Schedules the air-hockey sound requests (wall bounce, paddle hit, goal
// jingle) and drives the single square-wave tone generator behind SPEAKER.
// Event levels are edge-detected into pending requests. Requests are arbitrated
// by fixed priority (goal > paddle > wall) only on vSyncStart. Multi-note
// jingles are stepped one frame at a time.
module sound_sequencer #(
   parameter int CLK_HZ           = 40000000,
   parameter int WALL_FRAMES      = 2,
   parameter int PADDLE_FRAMES    = 2,
   parameter int GOAL_NOTE_FRAMES = 10,
   parameter int GOAL_LAST_FRAMES = 30,
   parameter int GAP_FRAMES       = 2,
   parameter int MAX_WAIT         = 8
) (
   input  logic        pixelClock,
   input  logic        resetN,
   input  logic        vSyncStart,
   input  logic        evWall,
   input  logic        evPaddle,
   input  logic        evGoal,
   output logic [25:0] toneHalfPeriod,
   output logic        toneEnable,
   output logic        toneRestart,
   output logic [1:0]  activeEvent,
   output logic        busy
);

   // Tone half-periods in pixelClock ticks, fixed at elaboration.
   localparam logic [25:0] HALF_WALL   = 26'(CLK_HZ / (2 * 750));
   localparam logic [25:0] HALF_PADDLE = 26'(CLK_HZ / (2 * 1000));
   localparam logic [25:0] HALF_GOAL0  = 26'(CLK_HZ / (2 * 500));
   localparam logic [25:0] HALF_GOAL1  = 26'(CLK_HZ / (2 * 250));
   localparam logic [25:0] HALF_GOAL2  = 26'(CLK_HZ / (2 * 100));

   // Note lengths in frames.
   localparam logic [5:0] LEN_WALL      = 6'(WALL_FRAMES);
   localparam logic [5:0] LEN_PADDLE    = 6'(PADDLE_FRAMES);
   localparam logic [5:0] LEN_GOAL_NOTE = 6'(GOAL_NOTE_FRAMES);
   localparam logic [5:0] LEN_GOAL_LAST = 6'(GOAL_LAST_FRAMES);
   localparam logic [5:0] LEN_GAP       = 6'(GAP_FRAMES);

   // The wait counter only needs to reach MAX_WAIT-1 before the request is dropped.
   localparam int                WAIT_W    = $clog2(MAX_WAIT + 1);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);
   localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);

   // Event codes double as priority levels, so a plain compare picks the winner.
   localparam logic [1:0] EV_NONE   = 2'd0;
   localparam logic [1:0] EV_WALL   = 2'd1;
   localparam logic [1:0] EV_PADDLE = 2'd2;
   localparam logic [1:0] EV_GOAL   = 2'd3;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] PLAY = 2'd1;
   localparam logic [1:0] GAP  = 2'd2;

   localparam logic [1:0] GOAL_LAST_IDX = 2'd2;

   logic [1:0]        state, stateNext;
   logic [5:0]        frameCnt, frameNext;
   logic [1:0]        noteIdx, noteNext, noteIdxPlusOne;
   logic [25:0]       halfNext;
   logic              enableNext, restartNext;
   logic [1:0]        eventNext;
   logic [1:0]        topPend, grantEv;

   logic              evWallQ, evPaddleQ, evGoalQ;
   logic              riseWall, risePaddle, riseGoal;
   logic              pendWall, pendPaddle, pendGoal;
   logic              pendWallNext, pendPaddleNext, pendGoalNext;
   logic [WAIT_W-1:0] waitWall, waitPaddle;
   logic [WAIT_W-1:0] waitWallNext, waitPaddleNext;

   // Half-period of a given note of a given event.
   function automatic logic [25:0] noteHalf(input logic [1:0] ev, input logic [1:0] idx);
      logic [25:0] h;
      h = '0;
      case (ev)
         EV_WALL:   h = HALF_WALL;
         EV_PADDLE: h = HALF_PADDLE;
         EV_GOAL: begin
            case (idx)
               2'd0:    h = HALF_GOAL0;
               2'd1:    h = HALF_GOAL1;
               default: h = HALF_GOAL2;
            endcase
         end
         default:   h = '0;
      endcase
      return h;
   endfunction

   // Length in frames of a given note of a given event.
   function automatic logic [5:0] noteFrames(input logic [1:0] ev, input logic [1:0] idx);
      logic [5:0] f;
      f = '0;
      case (ev)
         EV_WALL:   f = LEN_WALL;
         EV_PADDLE: f = LEN_PADDLE;
         EV_GOAL:   f = (idx == GOAL_LAST_IDX) ? LEN_GOAL_LAST : LEN_GOAL_NOTE;
         default:   f = '0;
      endcase
      return f;
   endfunction

   assign riseWall   = evWall   & ~evWallQ;
   assign risePaddle = evPaddle & ~evPaddleQ;
   assign riseGoal   = evGoal   & ~evGoalQ;

   assign busy = (state != IDLE);

   // Remember last cycle's event levels so a held level makes only one request.
   always_ff @(posedge pixelClock) begin
      if (!resetN) begin
         evWallQ   <= 1'b0;
         evPaddleQ <= 1'b0;
         evGoalQ   <= 1'b0;
      end else begin
         evWallQ   <= evWall;
         evPaddleQ <= evPaddle;
         evGoalQ   <= evGoal;
      end
   end

   // Highest-priority pending request.
   always_comb begin
      topPend = EV_NONE;
      if (pendGoal) begin
         topPend = EV_GOAL;
      end else if (pendPaddle) begin
         topPend = EV_PADDLE;
      end else if (pendWall) begin
         topPend = EV_WALL;
      end
   end

   // Frame-boundary scheduler: grants, preemption, note stepping and gaps.
   always_comb begin
      stateNext      = state;
      frameNext      = frameCnt;
      noteNext       = noteIdx;
      halfNext       = toneHalfPeriod;
      enableNext     = toneEnable;
      restartNext    = 1'b0;
      eventNext      = activeEvent;
      grantEv        = EV_NONE;
      noteIdxPlusOne = noteIdx + 2'd1;
      if (vSyncStart) begin
         case (state)
            IDLE: begin
               if (topPend != EV_NONE) begin
                  grantEv = topPend;
               end
            end
            PLAY: begin
               if (topPend > activeEvent) begin
                  grantEv = topPend;
               end else if (frameCnt <= 6'd1) begin
                  if ((activeEvent == EV_GOAL) && (noteIdx != GOAL_LAST_IDX)) begin
                     stateNext  = GAP;
                     frameNext  = LEN_GAP;
                     enableNext = 1'b0;
                  end else if (topPend != EV_NONE) begin
                     grantEv = topPend;
                  end else begin
                     stateNext  = IDLE;
                     frameNext  = '0;
                     enableNext = 1'b0;
                     eventNext  = EV_NONE;
                  end
               end else begin
                  frameNext = frameCnt - 6'd1;
               end
            end
            GAP: begin
               if (topPend > activeEvent) begin
                  grantEv = topPend;
               end else if (frameCnt <= 6'd1) begin
                  stateNext   = PLAY;
                  noteNext    = noteIdxPlusOne;
                  frameNext   = noteFrames(activeEvent, noteIdxPlusOne);
                  halfNext    = noteHalf(activeEvent, noteIdxPlusOne);
                  enableNext  = 1'b1;
                  restartNext = 1'b1;
               end else begin
                  frameNext = frameCnt - 6'd1;
               end
            end
            default: begin
               stateNext  = IDLE;
               enableNext = 1'b0;
               eventNext  = EV_NONE;
            end
         endcase
         if (grantEv != EV_NONE) begin
            stateNext   = PLAY;
            noteNext    = 2'd0;
            frameNext   = noteFrames(grantEv, 2'd0);
            halfNext    = noteHalf(grantEv, 2'd0);
            enableNext  = 1'b1;
            restartNext = 1'b1;
            eventNext   = grantEv;
         end
      end
   end

   // Pending requests: set on a rise, cleared by a grant or by going stale.
   always_comb begin
      pendWallNext   = pendWall;
      waitWallNext   = waitWall;
      pendPaddleNext = pendPaddle;
      waitPaddleNext = waitPaddle;
      pendGoalNext   = pendGoal;
      if (vSyncStart && pendWall) begin
         if ((grantEv == EV_WALL) || (waitWall == WAIT_LAST)) begin
            pendWallNext = 1'b0;
            waitWallNext = '0;
         end else begin
            waitWallNext = waitWall + WAIT_ONE;
         end
      end
      if (vSyncStart && pendPaddle) begin
         if ((grantEv == EV_PADDLE) || (waitPaddle == WAIT_LAST)) begin
            pendPaddleNext = 1'b0;
            waitPaddleNext = '0;
         end else begin
            waitPaddleNext = waitPaddle + WAIT_ONE;
         end
      end
      if (vSyncStart && (grantEv == EV_GOAL)) begin
         pendGoalNext = 1'b0;
      end
      if (riseWall) begin
         pendWallNext = 1'b1;
         waitWallNext = '0;
      end
      if (risePaddle) begin
         pendPaddleNext = 1'b1;
         waitPaddleNext = '0;
      end
      if (riseGoal) begin
         pendGoalNext = 1'b1;
      end
   end

   // Register scheduler state, pending requests and tone-generator controls.
   always_ff @(posedge pixelClock) begin
      if (!resetN) begin
         state          <= IDLE;
         frameCnt       <= '0;
         noteIdx        <= '0;
         toneHalfPeriod <= '0;
         toneEnable     <= 1'b0;
         toneRestart    <= 1'b0;
         activeEvent    <= EV_NONE;
         pendWall       <= 1'b0;
         pendPaddle     <= 1'b0;
         pendGoal       <= 1'b0;
         waitWall       <= '0;
         waitPaddle     <= '0;
      end else begin
         state          <= stateNext;
         frameCnt       <= frameNext;
         noteIdx        <= noteNext;
         toneHalfPeriod <= halfNext;
         toneEnable     <= enableNext;
         toneRestart    <= restartNext;
         activeEvent    <= eventNext;
         pendWall       <= pendWallNext;
         pendPaddle     <= pendPaddleNext;
         pendGoal       <= pendGoalNext;
         waitWall       <= waitWallNext;
         waitPaddle     <= waitPaddleNext;
      end
   end

endmodule
